game_state_fsm: RTL
===================

// Module: game_state_fsm
// PURPOSE
//  Parametrised successor to the single-key pause toggle. Debounces NUM_KEYS active-low
//  buttons and runs a five-state game-flow FSM (IDLE/COUNTDOWN/RUN/PAUSE/OVER).
//  Sits between the board buttons and the note scroller, scorer and audio player. Those
//  blocks gate on `running` and display `state`/`cd_sec`.
// PARAMETERS
//  NUM_KEYS     2    number of active-low buttons; >=2; key0=start/pause, key1=quit
//  DEBOUNCE_MS  20   ms a raw level must hold before the debounced level follows it
//  COUNTDOWN_S  3    seconds of countdown before RUN; 1..15
//  MS_PER_S     1000 tick_ms strobes per countdown second
// PORTS
//  clk        in   1         system clock
//  rst_n      in   1         reset, asynchronous, active-low
//  key_n      in   NUM_KEYS  raw buttons, asynchronous, 0=pressed
//  tick_ms    in   1         1-cycle strobe, once per ms
//  song_end   in   1         level/pulse from audio player: chart finished
//  key_press  out  NUM_KEYS  1-cycle pulse per debounced press (1->0 edge)
//  state      out  3         0=IDLE 1=COUNTDOWN 2=RUN 3=PAUSE 4=OVER
//  running    out  1         1 iff state==RUN (registered)
//  cd_sec     out  4         remaining countdown seconds; 0 outside COUNTDOWN
//  state_chg  out  1         1-cycle pulse on the cycle state takes a new value
// BEHAVIOUR
//  Reset (async assert, sync deassert by use):
//   - state=IDLE, running=0, cd_sec=0, key_press=0, state_chg=0
//   - debounced levels=1 (released), all counters=0
//  Debounce, per key:
//   - 2-flop synchroniser.
//   - On tick_ms, if sync!=stable, count++. If sync==stable, count=0.
//   - When count reaches DEBOUNCE_MS-1 on a tick: stable<=sync, count=0.
//   - key_press[i] pulses the cycle after stable goes 1->0. Release produces no pulse.
//   - Glitches shorter than DEBOUNCE_MS ticks never change stable.
//  FSM: transitions evaluate key_press/song_end and register on the next edge. state,
//   running and state_chg all update that same edge. Latency = 1 clk after key_press.
//   - IDLE:      key0 -> COUNTDOWN; cd_sec<=COUNTDOWN_S; ms counter=0
//   - COUNTDOWN: on tick_ms, ms++. When ms==MS_PER_S-1: ms=0, cd_sec--.
//                When cd_sec is 1 and the second expires -> RUN, cd_sec<=0.
//                key1 -> IDLE. key0 ignored.
//   - RUN:       song_end -> OVER; else key1 -> IDLE; else key0 -> PAUSE
//   - PAUSE:     key1 -> IDLE; else key0 -> COUNTDOWN (reload COUNTDOWN_S);
//                song_end ignored
//   - OVER:      key0 or key1 -> IDLE
//  Simultaneous events: priority song_end > key1 > key0. Keys pressed together
//   pulse in the same cycle, and only the highest-priority one acts.
//  Illegal state codes 5..7 -> IDLE next cycle, with a state_chg pulse.
//  Keys at index >=2 are debounced and reported on key_press only; the FSM ignores them.
//  Reset mid-countdown or mid-run: immediate IDLE. Held keys give no press after reset
//   until released and pressed again.
// CONFIGURATION
//  GAME_FSM_COUNTDOWN_EN defined:
//   - COUNTDOWN state and ms/second counters are built, as described above.
//  GAME_FSM_COUNTDOWN_EN undefined:
//   - IDLE key0 and PAUSE key0 go directly to RUN.
//   - cd_sec is tied to 0 and the COUNTDOWN code (1) is never produced.
//   - The ms/second counters are not instantiated.
// STRUCTURE
//  Package game_pkg: state encodings ST_IDLE..ST_OVER (3-bit localparams), KEY_START=0,
//   KEY_QUIT=1. Shared with the scorer and display blocks.
//  Sub-module key_debounce (param DEBOUNCE_MS): one key, ports clk, rst_n, key_n,
//   tick_ms, level, press. Generate-instantiated NUM_KEYS times.
//  FSM and countdown counters live in game_state_fsm itself.
// TESTING (DEBOUNCE_MS=2, MS_PER_S=4, COUNTDOWN_S=3, tick_ms every 10 clk)
//  1. Hold key0 low 30 clk -> one key_press[0] pulse, state IDLE->COUNTDOWN, cd_sec=3,
//     state_chg pulses once.
//  2. 12 ticks in COUNTDOWN -> cd_sec 3,2,1, then state=RUN, running=1, cd_sec=0.
//  3. 5-clk low glitch on key0 in RUN -> no key_press, state stays RUN.
//  4. Press key0 in RUN -> PAUSE. Pulse song_end in PAUSE -> stays PAUSE.
//     Press key0 -> COUNTDOWN, cd_sec=3.
//  5. In RUN, song_end and key1 press in the same cycle -> OVER. Press key1 -> IDLE.
//  6. Assert rst_n=0 mid-COUNTDOWN with key0 held -> state=IDLE, cd_sec=0 immediately.
//     After release, no key_press until key0 is released and pressed again.
//     Macro-off build: test 1 goes IDLE->RUN directly.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow encodings: state codes for the FSM, scorer and display,
// plus the button roles.
package game_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_PAUSE     = 3'd3;
    localparam logic [2:0] ST_OVER      = 3'd4;

    localparam int KEY_START = 0;
    localparam int KEY_QUIT  = 1;

endpackage

// File: rtl/key_debounce.sv
// One active-low button: 2-flop synchroniser, ms-tick debounce counter, and a
// one-cycle press pulse on each debounced 1->0 edge.
module key_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    input  logic tick_ms,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          armed_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (tick_ms) begin
            if (sync2_q != stable_q) begin
                if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
                    stable_d = sync2_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Synchronisers reset to "pressed" and presses stay disarmed until the raw
    // key has been seen released, so a key held through reset never pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_q | sync2_q;
            press_q  <= armed_q & stable_q & ~stable_d;
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/game_state_fsm.sv
// Button debouncing plus the IDLE/COUNTDOWN/RUN/PAUSE/OVER game-flow FSM.
// Define GAME_FSM_COUNTDOWN_EN to build the COUNTDOWN state and its counters.
module game_state_fsm
    import game_pkg::*;
#(
    parameter int NUM_KEYS    = 2,
    parameter int DEBOUNCE_MS = 20,
    parameter int COUNTDOWN_S = 3,
    parameter int MS_PER_S    = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                tick_ms,
    input  logic                song_end,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [2:0]          state,
    output logic                running,
    output logic [3:0]          cd_sec,
    output logic                state_chg
);

    logic [NUM_KEYS-1:0] key_level;
    logic                key_start, key_quit;
    logic [2:0]          state_q, state_d;
    logic                running_q, chg_q;
    logic                unused_cfg;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_n   (key_n[gi]),
            .tick_ms (tick_ms),
            .level   (key_level[gi]),
            .press   (key_press[gi])
        );
    end

    assign key_start = key_press[KEY_START];
    assign key_quit  = key_press[KEY_QUIT];

`ifdef GAME_FSM_COUNTDOWN_EN
    localparam logic [2:0] ST_START = ST_COUNTDOWN;
    localparam int MS_W = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;

    logic [MS_W-1:0] ms_q, ms_d;
    logic [3:0]      cd_q, cd_d;
    logic            cd_done;

    assign cd_done = tick_ms && (ms_q == MS_W'(MS_PER_S - 1)) && (cd_q == 4'd1);

    // Counters follow the FSM's next state: reload on entry, clear on exit.
    always_comb begin
        ms_d = ms_q;
        cd_d = cd_q;
        if (state_d != ST_COUNTDOWN) begin
            ms_d = '0;
            cd_d = '0;
        end else if (state_q != ST_COUNTDOWN) begin
            ms_d = '0;
            cd_d = 4'(COUNTDOWN_S);
        end else if (tick_ms) begin
            if (ms_q == MS_W'(MS_PER_S - 1)) begin
                ms_d = '0;
                cd_d = cd_q - 4'd1;
            end else begin
                ms_d = ms_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_q <= '0;
            cd_q <= '0;
        end else begin
            ms_q <= ms_d;
            cd_q <= cd_d;
        end
    end

    assign cd_sec     = cd_q;
    assign unused_cfg = ^key_level;
`else
    localparam logic [2:0] ST_START = ST_RUN;

    assign cd_sec     = 4'd0;
    assign unused_cfg = ^{key_level, 32'(COUNTDOWN_S), 32'(MS_PER_S)};
`endif

    // Priority within every state: song_end > quit > start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (key_start) state_d = ST_START;
            end
`ifdef GAME_FSM_COUNTDOWN_EN
            ST_COUNTDOWN: begin
                if (key_quit)     state_d = ST_IDLE;
                else if (cd_done) state_d = ST_RUN;
            end
`endif
            ST_RUN: begin
                if (song_end)       state_d = ST_OVER;
                else if (key_quit)  state_d = ST_IDLE;
                else if (key_start) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (key_quit)       state_d = ST_IDLE;
                else if (key_start) state_d = ST_START;
            end
            ST_OVER: begin
                if (key_start || key_quit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            chg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
            chg_q     <= (state_d != state_q);
        end
    end

    assign state     = state_q;
    assign running   = running_q;
    assign state_chg = chg_q;

endmodule
